// File: rtl/sram_ctrl_pkg.sv
// Shared constants, request record and round-robin helper for the SRAM port arbiter.
package sram_ctrl_pkg;

    localparam int SRAM_DATA_WIDTH = 32;
    localparam int SRAM_ADDR_WIDTH = 5;
    localparam int MAX_REQ         = 8;

    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select over N requesters; the scan starts at rr_ptr_q and the
// pointer moves just past the winner on every grant (a grant is always a transfer).
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en_i,
    input  logic [N-1:0]                         valid_i,
    output logic [N-1:0]                         grant_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] win_id_o,
    output logic                                 win_valid_o
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] win_id;
    logic           win_valid;

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(rr_ptr_q) + k) % N);
            if (en_i && !win_valid && valid_i[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (win_valid) begin
            grant_o[win_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_valid) begin
            rr_ptr_d = IDW'(rr_next(32'(win_id), 32'(N)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign win_id_o    = win_id;
    assign win_valid_o = win_valid;

endmodule

// File: rtl/sram_rr_port_arbiter.sv
// Fronts one single-port SRAM macro for NUM_REQ requesters: one access per clock,
// round-robin fair, responses routed back exactly one cycle after the grant.
module sram_rr_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_din,
    input  logic [DATA_WIDTH-1:0]         sram_dout
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0] win_id;
    logic           win_valid;
    sram_req_t      win_req;

    logic           pend_valid_q, pend_valid_d;
    logic [IDW-1:0] pend_id_q, pend_id_d;
    logic           pend_we_q, pend_we_d;

    // Arbitration is gated by rst_n so nothing is granted or driven while in reset.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (rst_n),
        .valid_i    (req_valid),
        .grant_o    (req_ready),
        .win_id_o   (win_id),
        .win_valid_o(win_valid)
    );

    always_comb begin
        win_req = '0;
        if (win_valid) begin
            win_req.we    = req_we[win_id];
            win_req.addr  = req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
            win_req.wdata = req_wdata[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign sram_we   = win_req.we;
    assign sram_addr = win_req.addr;
    assign sram_din  = win_req.wdata;

    always_comb begin
        pend_valid_d = win_valid;
        pend_id_d    = pend_id_q;
        pend_we_d    = pend_we_q;
        if (win_valid) begin
            pend_id_d = win_id;
            pend_we_d = win_req.we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            pend_we_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_we_q    <= pend_we_d;
        end
    end

    // Write cycles leave the macro's dout undefined, so read data is masked to zero.
    always_comb begin
        resp_valid = '0;
        if (pend_valid_q) begin
            resp_valid[pend_id_q] = 1'b1;
        end
        resp_rdata = (pend_valid_q && !pend_we_q) ? sram_dout : '0;
    end

endmodule
